// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and flag bit layout for alu_exec.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_WB_LO   = 2'd2,
    ST_WB_HI   = 2'd3
  } state_e;

  localparam int FLAG_S  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_P  = 1;
  localparam int FLAG_CY = 0;

  // Packs individual flag bits into the {S, Z, P, CY} flag vector.
  function automatic logic [3:0] pack_flags(input logic s, input logic z,
                                            input logic p, input logic cy);
    logic [3:0] f;
    f = '0;
    f[FLAG_S]  = s;
    f[FLAG_Z]  = z;
    f[FLAG_P]  = p;
    f[FLAG_CY] = cy;
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_shift_add_mul.sv
// Iterative shift-add multiplier: one partial-product add per cycle while run is high.
// done flags the final step; product_next is the full product available on that step,
// so the FSM can register the low byte and flags on the same edge the last add lands.
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  run,
  input  logic [DATA_W-1:0]     opa,
  input  logic [DATA_W-1:0]     opb,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product_next,
  output logic [DATA_W-1:0]     product_hi
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
  logic [2*DATA_W-1:0] step_sum;

  // Next-state for operand latches, step counter and accumulated product.
  always_comb begin
    step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    done     = run && (cnt_q == CNT_W'(DATA_W - 1));
    if (start) begin
      mcand_d  = {{DATA_W{1'b0}}, opa};
      mplier_d = opb;
      cnt_d    = '0;
      prod_d   = '0;
    end else if (run) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      prod_d   = step_sum;
    end
  end

  assign product_next = step_sum;
  assign product_hi   = prod_q[2*DATA_W-1:DATA_W];

  // Multiplier state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Single-issue ALU with registered write-back and a multi-cycle MUL.
//   state      | meaning
//   ST_IDLE    | accepting requests; ops 0-6 complete here in one cycle
//   ST_MUL_RUN | multiplier stepping, one shift-add per cycle
//   ST_WB_LO   | writing product low byte to dest
//   ST_WB_HI   | writing product high byte to dest+1
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [RADDR_W-1:0] dest,
  input  logic [DATA_W-1:0]  opa,
  input  logic [DATA_W-1:0]  opb,
  output logic               regwrite,
  output logic [RADDR_W-1:0] writereg,
  output logic [DATA_W-1:0]  data,
  output logic [3:0]         flags,
  output logic               busy
);

  state_e               state_q, state_d;
  logic                 regwrite_q, regwrite_d;
  logic [RADDR_W-1:0]   writereg_q, writereg_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [3:0]           flags_q, flags_d;
  logic [RADDR_W-1:0]   dest_q, dest_d;

  logic [DATA_W-1:0]    alu_res;
  logic                 alu_cy;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*DATA_W-1:0]  mul_next;
  logic [DATA_W-1:0]    mul_hi;

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);

  shift_add_mul #(.DATA_W(DATA_W)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .run          (state_q == ST_MUL_RUN),
    .opa          (opa),
    .opb          (opb),
    .done         (mul_done),
    .product_next (mul_next),
    .product_hi   (mul_hi)
  );

  // Single-cycle ALU result and carry/borrow.
  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (op)
      OP_ADD:         {alu_cy, alu_res} = {1'b0, opa} + {1'b0, opb};
      OP_SUB, OP_CMP: begin
        alu_res = opa - opb;
        alu_cy  = (opa < opb);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_XOR:  alu_res = opa ^ opb;
      OP_MOV:  alu_res = opb;
      default: alu_res = '0;
    endcase
  end

  // FSM next state and next values of the registered write-back outputs.
  always_comb begin
    state_d    = state_q;
    regwrite_d = 1'b0;
    writereg_d = writereg_q;
    data_d     = data_q;
    flags_d    = flags_q;
    dest_d     = dest_q;
    mul_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            dest_d    = dest;
            state_d   = ST_MUL_RUN;
          end else begin
            if (op != OP_CMP) begin
              regwrite_d = 1'b1;
              writereg_d = dest;
              data_d     = alu_res;
            end
            if (op != OP_MOV) begin
              flags_d = pack_flags(alu_res[DATA_W-1], alu_res == '0, ~^alu_res, alu_cy);
            end
          end
        end
      end
      ST_MUL_RUN: begin
        if (mul_done) begin
          state_d    = ST_WB_LO;
          regwrite_d = 1'b1;
          writereg_d = dest_q;
          data_d     = mul_next[DATA_W-1:0];
          flags_d    = pack_flags(mul_next[2*DATA_W-1], mul_next == '0,
                                  ~^mul_next[DATA_W-1:0],
                                  mul_next[2*DATA_W-1:DATA_W] != '0);
        end
      end
      ST_WB_LO: begin
        state_d    = ST_WB_HI;
        regwrite_d = 1'b1;
        writereg_d = dest_q + RADDR_W'(1);
        data_d     = mul_hi;
      end
      ST_WB_HI: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset wins over any request on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      regwrite_q <= 1'b0;
      writereg_q <= '0;
      data_q     <= '0;
      flags_q    <= '0;
      dest_q     <= '0;
    end else begin
      state_q    <= state_d;
      regwrite_q <= regwrite_d;
      writereg_q <= writereg_d;
      data_q     <= data_d;
      flags_q    <= flags_d;
      dest_q     <= dest_d;
    end
  end

  assign regwrite = regwrite_q;
  assign writereg = writereg_q;
  assign data     = data_q;
  assign flags    = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: single-cycle op table plus MUL and reset sequences.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [1:0] dest;
  logic [7:0] opa, opb;
  logic       regwrite;
  logic [1:0] writereg;
  logic [7:0] data;
  logic [3:0] flags;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] cap [4];

  typedef struct {
    logic [2:0] op;
    logic [1:0] dest;
    logic [7:0] a;
    logic [7:0] b;
    logic       rw;
    logic [1:0] wr;
    logic [7:0] d;
    logic [3:0] f;
  } vec_t;

  vec_t vecs [14];

  alu_exec #(.DATA_W(8), .RADDR_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .dest     (dest),
    .opa      (opa),
    .opb      (opb),
    .regwrite (regwrite),
    .writereg (writereg),
    .data     (data),
    .flags    (flags),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a MUL and follows it through its occupancy window (samples after E0..E10).
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [1:0] d,
                         input logic hold_add, output int low_cnt, output int rw_cnt,
                         output int busy_err, output logic [3:0] f_lo);
    in_valid = 1'b1; op = 3'd7; opa = a; opb = b; dest = d;
    step();
    if (hold_add) begin
      op = 3'd0; opa = 8'h01; opb = 8'h02; dest = 2'd3;
    end else begin
      in_valid = 1'b0;
    end
    low_cnt = 0; rw_cnt = 0; busy_err = 0; f_lo = 4'hx;
    for (int i = 0; i <= 10; i++) begin
      if (!in_ready) low_cnt++;
      if (busy !== !in_ready) busy_err++;
      if (regwrite === 1'b1) begin
        rw_cnt++;
        cap[writereg] = data;
        if (rw_cnt == 1) f_lo = flags;
      end
      if (i < 10) step();
    end
  endtask

  initial begin
    int low_cnt, rw_cnt, busy_err, rw_seen;
    logic [3:0] f_lo;

    //            op    dest   a      b      rw    wr     d      f
    vecs[0]  = '{3'd0, 2'd2, 8'hFF, 8'h01, 1'b1, 2'd2, 8'h00, 4'b0111};
    vecs[1]  = '{3'd1, 2'd1, 8'h10, 8'h20, 1'b1, 2'd1, 8'hF0, 4'b1011};
    vecs[2]  = '{3'd6, 2'd3, 8'h05, 8'h05, 1'b0, 2'd1, 8'hF0, 4'b0110};
    vecs[3]  = '{3'd5, 2'd0, 8'h00, 8'hA5, 1'b1, 2'd0, 8'hA5, 4'b0110};
    vecs[4]  = '{3'd2, 2'd3, 8'hF0, 8'h3C, 1'b1, 2'd3, 8'h30, 4'b0010};
    vecs[5]  = '{3'd3, 2'd1, 8'h81, 8'h02, 1'b1, 2'd1, 8'h83, 4'b1000};
    vecs[6]  = '{3'd4, 2'd2, 8'hAA, 8'hAA, 1'b1, 2'd2, 8'h00, 4'b0110};
    vecs[7]  = '{3'd0, 2'd0, 8'h7F, 8'h01, 1'b1, 2'd0, 8'h80, 4'b1000};
    vecs[8]  = '{3'd1, 2'd1, 8'h03, 8'h01, 1'b1, 2'd1, 8'h02, 4'b0000};
    vecs[9]  = '{3'd0, 2'd3, 8'h80, 8'h80, 1'b1, 2'd3, 8'h00, 4'b0111};
    vecs[10] = '{3'd5, 2'd2, 8'h33, 8'h5A, 1'b1, 2'd2, 8'h5A, 4'b0111};
    vecs[11] = '{3'd4, 2'd0, 8'h0F, 8'hF0, 1'b1, 2'd0, 8'hFF, 4'b1010};
    vecs[12] = '{3'd6, 2'd1, 8'h02, 8'h03, 1'b0, 2'd0, 8'hFF, 4'b1011};
    vecs[13] = '{3'd3, 2'd1, 8'h00, 8'h00, 1'b1, 2'd1, 8'h00, 4'b0110};

    rst_n = 1'b0; in_valid = 1'b0; op = '0; dest = '0; opa = '0; opb = '0;
    repeat (3) step();
    check("rst regwrite", regwrite, 0);
    check("rst writereg", writereg, 0);
    check("rst data", data, 0);
    check("rst flags", flags, 0);
    check("rst in_ready", in_ready, 1);
    check("rst busy", busy, 0);
    rst_n = 1'b1;
    step();

    // Back-to-back single-cycle ops.
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; op = vecs[i].op; dest = vecs[i].dest; opa = vecs[i].a; opb = vecs[i].b;
      step();
      check($sformatf("v%0d regwrite", i), regwrite, vecs[i].rw);
      check($sformatf("v%0d writereg", i), writereg, vecs[i].wr);
      check($sformatf("v%0d data", i), data, vecs[i].d);
      check($sformatf("v%0d flags", i), flags, vecs[i].f);
      check($sformatf("v%0d in_ready", i), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    check("idle regwrite drop", regwrite, 0);
    check("idle data hold", data, 8'h00);

    // MUL 0x0F * 0x11 into reg3 / reg0.
    for (int i = 0; i < 4; i++) cap[i] = 8'hEE;
    run_mul(8'h0F, 8'h11, 2'd3, 1'b0, low_cnt, rw_cnt, busy_err, f_lo);
    check("mul1 in_ready low cycles", low_cnt, 10);
    check("mul1 regwrite cycles", rw_cnt, 2);
    check("mul1 busy tracks", busy_err, 0);
    check("mul1 reg3", cap[3], 8'hFF);
    check("mul1 reg0", cap[0], 8'h00);
    check("mul1 flags at lo", f_lo, 4'b0010);
    check("mul1 flags after", flags, 4'b0010);
    check("mul1 in_ready end", in_ready, 1);
    check("mul1 regwrite end", regwrite, 0);

    // MUL 0xFF * 0xFF into reg1 / reg2 with an ADD held on the inputs throughout.
    for (int i = 0; i < 4; i++) cap[i] = 8'hEE;
    run_mul(8'hFF, 8'hFF, 2'd1, 1'b1, low_cnt, rw_cnt, busy_err, f_lo);
    check("mul2 in_ready low cycles", low_cnt, 10);
    check("mul2 regwrite cycles", rw_cnt, 2);
    check("mul2 busy tracks", busy_err, 0);
    check("mul2 reg1", cap[1], 8'h01);
    check("mul2 reg2", cap[2], 8'hFE);
    check("mul2 reg3 untouched", cap[3], 8'hEE);
    check("mul2 flags at lo", f_lo, 4'b1001);
    check("mul2 regwrite at ready", regwrite, 0);
    step();
    in_valid = 1'b0;
    check("held add regwrite", regwrite, 1);
    check("held add writereg", writereg, 3);
    check("held add data", data, 8'h03);
    check("held add flags", flags, 4'b0010);

    // Reset in the fourth MUL_RUN cycle aborts the multiply.
    in_valid = 1'b1; op = 3'd0; opa = 8'h7F; opb = 8'h01; dest = 2'd1;
    step();
    check("pre-abort data", data, 8'h80);
    op = 3'd7; opa = 8'h0F; opb = 8'h11; dest = 2'd0;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("abort busy before rst", busy, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort regwrite", regwrite, 0);
    check("abort writereg", writereg, 0);
    check("abort data", data, 0);
    check("abort flags", flags, 0);
    check("abort in_ready", in_ready, 1);
    rw_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (regwrite !== 1'b0) rw_seen++;
    end
    check("abort no writeback", rw_seen, 0);

    // Reset beats a simultaneous request.
    in_valid = 1'b1; op = 3'd0; opa = 8'h01; opb = 8'h01; dest = 2'd2;
    step();
    check("prio setup data", data, 8'h02);
    opa = 8'h03; opb = 8'h04;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check("prio regwrite", regwrite, 0);
    check("prio data", data, 0);
    step();
    check("prio dropped", regwrite, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
